// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: a shadow pipeline of in-flight writers
// supplies the youngest matching result to each ID operand and stalls on loads.
module fwd_hazard_unit #(
   parameter int XLEN       = 32,
   parameter int RB         = 5,
   parameter int NUM_SRC    = 4,
   parameter int STAGES     = 3,
   parameter int LOAD_READY = 1,
   parameter int CNT_W      = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      id_valid_i,
   input  logic                      id_we_i,
   input  logic                      id_load_i,
   input  logic [RB-1:0]             id_dst_i,
   input  logic [NUM_SRC-1:0]        id_src_used_i,
   input  logic [NUM_SRC*RB-1:0]     id_src_pos_i,
   input  logic [NUM_SRC*XLEN-1:0]   id_src_data_i,
   input  logic [STAGES*XLEN-1:0]    stage_data_i,
   input  logic                      flush_i,
   output logic [NUM_SRC*XLEN-1:0]   src_data_out_o,
   output logic                      stall_o,
   output logic [CNT_W-1:0]          stall_count_o
);

   typedef struct packed {
      logic          v;
      logic          we;
      logic          ld;
      logic [RB-1:0] dst;
   } ent_t;

   ent_t             ent_q [STAGES];
   ent_t             ent_d [STAGES];
   logic [CNT_W-1:0] stall_count_q;
   logic [CNT_W-1:0] stall_count_d;

   logic [NUM_SRC-1:0]      src_hit;
   logic [NUM_SRC-1:0]      src_hazard;
   logic [NUM_SRC*XLEN-1:0] fwd_data;
   logic                    stall;

   // Scan stages from youngest (EX) to oldest; the first hit decides both the
   // forwarded value and whether that writer is a load whose data is not ready.
   always_comb begin
      src_hit    = '0;
      src_hazard = '0;
      fwd_data   = id_src_data_i;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = 0; k < STAGES; k++) begin
            if (!src_hit[i]
                && id_src_used_i[i]
                && ent_q[k].v
                && ent_q[k].we
                && (ent_q[k].dst == id_src_pos_i[i*RB +: RB])
                && (id_src_pos_i[i*RB +: RB] != '0)) begin
               src_hit[i]                  = 1'b1;
               fwd_data[i*XLEN +: XLEN]    = stage_data_i[k*XLEN +: XLEN];
               src_hazard[i]               = ent_q[k].ld && (k < LOAD_READY);
            end
         end
      end
   end

   assign stall          = (|src_hazard) && id_valid_i && !flush_i;
   assign stall_o        = stall;
   assign src_data_out_o = fwd_data;
   assign stall_count_o  = stall_count_q;

   // A stalled or flushed ID instruction enters EX as a bubble.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         ent_d[k] = '0;
      end
      if (id_valid_i && !stall && !flush_i) begin
         ent_d[0].v   = 1'b1;
         ent_d[0].we  = id_we_i;
         ent_d[0].ld  = id_load_i;
         ent_d[0].dst = id_dst_i;
      end
      for (int k = 1; k < STAGES; k++) begin
         ent_d[k] = ent_q[k-1];
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < STAGES; k++) begin
            ent_q[k] <= '0;
         end
         stall_count_q <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            ent_q[k] <= ent_d[k];
         end
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; a second instance with a 4-bit counter
// exercises stall-count saturation in a short run.
module tb_fwd_hazard_unit;

   localparam int XLEN    = 32;
   localparam int RB      = 5;
   localparam int NUM_SRC = 4;
   localparam int STAGES  = 3;

   logic                    clk;
   logic                    rstN;
   logic                    idValid;
   logic                    idWe;
   logic                    idLoad;
   logic [RB-1:0]           idDst;
   logic [NUM_SRC-1:0]      idSrcUsed;
   logic [NUM_SRC*RB-1:0]   idSrcPos;
   logic [NUM_SRC*XLEN-1:0] idSrcData;
   logic [STAGES*XLEN-1:0]  stageData;
   logic                    flush;
   logic [NUM_SRC*XLEN-1:0] srcOut;
   logic                    stall;
   logic [15:0]             stallCount;
   logic [NUM_SRC*XLEN-1:0] satSrcOut;
   logic                    satStall;
   logic [3:0]              satCount;

   int compared;
   int mismatched;

   fwd_hazard_unit dut (
      .clk_i(clk), .rst_ni(rstN), .id_valid_i(idValid), .id_we_i(idWe),
      .id_load_i(idLoad), .id_dst_i(idDst), .id_src_used_i(idSrcUsed),
      .id_src_pos_i(idSrcPos), .id_src_data_i(idSrcData),
      .stage_data_i(stageData), .flush_i(flush), .src_data_out_o(srcOut),
      .stall_o(stall), .stall_count_o(stallCount)
   );

   fwd_hazard_unit #(.CNT_W(4)) satDut (
      .clk_i(clk), .rst_ni(rstN), .id_valid_i(idValid), .id_we_i(idWe),
      .id_load_i(idLoad), .id_dst_i(idDst), .id_src_used_i(idSrcUsed),
      .id_src_pos_i(idSrcPos), .id_src_data_i(idSrcData),
      .stage_data_i(stageData), .flush_i(flush), .src_data_out_o(satSrcOut),
      .stall_o(satStall), .stall_count_o(satCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [XLEN-1:0] opOut(input int i);
      return srcOut[i*XLEN +: XLEN];
   endfunction

   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic setId(input logic v, input logic we, input logic ld, input logic [RB-1:0] dst);
      idValid = v;
      idWe    = we;
      idLoad  = ld;
      idDst   = dst;
   endtask

   task automatic clearReads();
      idSrcUsed = '0;
      idSrcPos  = '0;
   endtask

   task automatic setRead(input int op, input logic [RB-1:0] r);
      idSrcUsed[op]          = 1'b1;
      idSrcPos[op*RB +: RB]  = r;
   endtask

   task automatic drain();
      flush = 1'b0;
      setId(1'b0, 1'b0, 1'b0, '0);
      clearReads();
      repeat (STAGES) stepClk();
   endtask

   // Operand i reads 0xD0+i from the register file; stages EX/MEM/WB produce 0x11/0x22/0x33.
   task automatic applyStimulus();
      idSrcData = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      stageData = {32'h33, 32'h22, 32'h11};
      flush     = 1'b0;
      setId(1'b0, 1'b0, 1'b0, '0);
      clearReads();
      rstN = 1'b0;
      setRead(0, 5'd8);
      #3;
      checkOutput("reset_stall", {63'd0, stall}, 64'd0);
      checkOutput("reset_count", {48'd0, stallCount}, 64'd0);
      checkOutput("reset_op0", {32'd0, opOut(0)}, 64'hD0);
      #9 rstN = 1'b1;

      // ALU chain
      drain();
      setId(1'b1, 1'b1, 1'b0, 5'd8);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd10);
      setRead(0, 5'd8);
      setRead(1, 5'd3);
      setRead(2, 5'd8);
      idSrcUsed[2] = 1'b0;
      #1;
      checkOutput("alu_fwd_ex", {32'd0, opOut(0)}, 64'h11);
      checkOutput("alu_nomatch", {32'd0, opOut(1)}, 64'hD1);
      checkOutput("alu_unused", {32'd0, opOut(2)}, 64'hD2);
      checkOutput("alu_stall", {63'd0, stall}, 64'd0);

      // Youngest writer wins; non-writers are ignored
      drain();
      setId(1'b1, 1'b1, 1'b0, 5'd8);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd8);
      stepClk();
      setId(1'b0, 1'b0, 1'b0, '0);
      setRead(0, 5'd8);
      #1;
      checkOutput("prio_ex_over_mem", {32'd0, opOut(0)}, 64'h11);
      drain();
      setId(1'b1, 1'b1, 1'b0, 5'd8);
      stepClk();
      setId(1'b1, 1'b0, 1'b0, 5'd8);
      stepClk();
      setId(1'b0, 1'b0, 1'b0, '0);
      setRead(0, 5'd8);
      #1;
      checkOutput("prio_ex_nowe_mem", {32'd0, opOut(0)}, 64'h22);
      stepClk();
      checkOutput("prio_wb", {32'd0, opOut(0)}, 64'h33);

      // Load-use: one stall, bubble into EX, then forward from MEM
      drain();
      setId(1'b1, 1'b1, 1'b1, 5'd9);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd10);
      setRead(2, 5'd9);
      #1;
      checkOutput("lu_stall", {63'd0, stall}, 64'd1);
      checkOutput("lu_count_before", {48'd0, stallCount}, 64'd0);
      stepClk();
      checkOutput("lu_stall_clear", {63'd0, stall}, 64'd0);
      checkOutput("lu_fwd_mem", {32'd0, opOut(2)}, 64'h22);
      checkOutput("lu_count_after", {48'd0, stallCount}, 64'd1);
      setRead(1, 5'd10);
      #1;
      checkOutput("lu_bubble", {32'd0, opOut(1)}, 64'hD1);
      stepClk();
      checkOutput("lu_issue_ex", {32'd0, opOut(1)}, 64'h11);
      checkOutput("lu_load_wb", {32'd0, opOut(2)}, 64'h33);
      checkOutput("lu_issue_stall", {63'd0, stall}, 64'd0);

      // Young load shadows an older ALU writer of the same register
      drain();
      setId(1'b1, 1'b1, 1'b0, 5'd9);
      stepClk();
      setId(1'b1, 1'b1, 1'b1, 5'd9);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd10);
      setRead(0, 5'd9);
      #1;
      checkOutput("shadow_stall", {63'd0, stall}, 64'd1);
      stepClk();
      checkOutput("shadow_count", {48'd0, stallCount}, 64'd2);

      // Register 0 never forwards nor stalls
      drain();
      setId(1'b1, 1'b1, 1'b0, 5'd0);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd10);
      setRead(0, 5'd0);
      #1;
      checkOutput("r0_nofwd", {32'd0, opOut(0)}, 64'hD0);
      drain();
      setId(1'b1, 1'b1, 1'b1, 5'd0);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd10);
      setRead(0, 5'd0);
      #1;
      checkOutput("r0_nostall", {63'd0, stall}, 64'd0);

      // Flush overrides a pending load-use stall
      drain();
      setId(1'b1, 1'b1, 1'b1, 5'd9);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd10);
      setRead(0, 5'd9);
      flush = 1'b1;
      #1;
      checkOutput("flush_stall", {63'd0, stall}, 64'd0);
      stepClk();
      flush = 1'b0;
      setId(1'b0, 1'b0, 1'b0, '0);
      setRead(1, 5'd10);
      #1;
      checkOutput("flush_count", {48'd0, stallCount}, 64'd2);
      checkOutput("flush_bubble", {32'd0, opOut(1)}, 64'hD1);
      checkOutput("flush_load_mem", {32'd0, opOut(0)}, 64'h22);

      // Asynchronous reset in the middle of a stall
      drain();
      setId(1'b1, 1'b1, 1'b1, 5'd9);
      stepClk();
      setId(1'b1, 1'b1, 1'b0, 5'd10);
      setRead(0, 5'd9);
      #1;
      checkOutput("rst_pre_stall", {63'd0, stall}, 64'd1);
      rstN = 1'b0;
      #1;
      checkOutput("rst_mid_stall", {63'd0, stall}, 64'd0);
      checkOutput("rst_mid_count", {48'd0, stallCount}, 64'd0);
      checkOutput("rst_mid_op", {32'd0, opOut(0)}, 64'hD0);
      rstN = 1'b1;
      stepClk();
      checkOutput("rst_resume_stall", {63'd0, stall}, 64'd0);
      checkOutput("rst_resume_fwd", {32'd0, opOut(0)}, 64'hD0);

      // Back-to-back lw $9 reading $9 stalls on every other edge
      rstN = 1'b0;
      #1;
      rstN = 1'b1;
      setId(1'b1, 1'b1, 1'b1, 5'd9);
      clearReads();
      setRead(0, 5'd9);
      repeat (30) stepClk();
      checkOutput("sat_main_15", {48'd0, stallCount}, 64'd15);
      checkOutput("sat_small_15", {60'd0, satCount}, 64'hF);
      repeat (2) stepClk();
      checkOutput("sat_main_16", {48'd0, stallCount}, 64'd16);
      checkOutput("sat_small_hold", {60'd0, satCount}, 64'hF);
      repeat (10) stepClk();
      checkOutput("sat_small_hold2", {60'd0, satCount}, 64'hF);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      applyStimulus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
